// File: rtl/acc_mem_host.sv
`timescale 1ns/1ps
// acc_mem_host
// Memory responder and frame sequencer for the edge-detection accelerator.
// Owns one single-port word RAM: input image at words 0..IMG_WORDS-1, output
// image at words IMG_WORDS..DEPTH-1. Frames are streamed in over the load
// port, the accelerator is kicked with `start`, it works on the RAM over the
// addr/en/we/dataW/dataR bus, and after `finish` the output image is drained
// over the dump port.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   addr, dataW, en, we, dataR  accelerator memory bus (1-cycle read latency)
//   start                       one-cycle start pulse to the accelerator
//   finish                      accelerator completion level (sampled in RUN)
//   load_valid/ready/data       host input word stream
//   dump_valid/ready/data       output word stream (2-entry skid FIFO)
//   frame_done                  pulse after the last output word is accepted
//   frames                      completed-frame counter, wraps 255->0
//   err                         sticky out-of-range flag (only when the
//                               ACC_MEM_BOUNDS_CHECK_EN macro is defined)
module acc_mem_host #(
    parameter int IMG_WORDS = 25344,
    parameter int DEPTH     = 2 * IMG_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [31:0] dataW,
    input  logic        en,
    input  logic        we,
    output logic [31:0] dataR,
    output logic        start,
    input  logic        finish,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        dump_valid,
    output logic [31:0] dump_data,
    input  logic        dump_ready,
    output logic        frame_done,
`ifdef ACC_MEM_BOUNDS_CHECK_EN
    output logic        err,
`endif
    output logic [7:0]  frames
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [16:0]     DEPTH_A  = 17'(DEPTH);
    localparam logic [AW:0]     IMG_P    = (AW+1)'(IMG_WORDS);
    localparam logic [AW:0]     DEPTH_P  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(IMG_WORDS - 1);

    typedef enum logic [1:0] {S_LOAD, S_START, S_RUN, S_DUMP} state_e;
    state_e state_q, state_d;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_q;

    logic [AW-1:0] load_ptr_q;
    logic [AW-1:0] out_cnt_q;
    logic [AW:0]   dump_ptr_q;
    logic          dump_pend_q;
    logic [31:0]   fifo_q [2];
    logic          fifo_wr_q;
    logic          fifo_rd_q;
    logic [1:0]    fifo_cnt_q;
    logic          acc_rd_q;
    logic          acc_zero_q;
    logic [31:0]   data_r_hold_q;
    logic          start_q;
    logic          load_ready_q;
    logic          frame_done_q;
    logic [7:0]    frames_q;

    logic          acc_oor, acc_rd, acc_wr, acc_rd_zero;
    logic          load_fire, load_last;
    logic          dump_pop, dump_last, dump_rd;
    logic [1:0]    occ_after;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;

    assign acc_oor     = ({1'b0, addr} >= DEPTH_A);
    assign acc_wr      = (state_q == S_RUN) & en & we & ~acc_oor;
    assign acc_rd      = (state_q == S_RUN) & en & ~we & ~acc_oor;
    assign acc_rd_zero = (state_q == S_RUN) & en & ~we & acc_oor;

    assign load_fire   = (state_q == S_LOAD) & load_valid & load_ready_q;
    assign load_last   = load_fire & (load_ptr_q == LAST_IDX);

    assign dump_valid  = (fifo_cnt_q != 2'd0);
    assign dump_data   = fifo_q[fifo_rd_q];
    assign dump_pop    = dump_valid & dump_ready;
    assign dump_last   = dump_pop & (out_cnt_q == LAST_IDX);

    // Occupancy once this cycle's pop and the in-flight read have settled.
    // Issuing only while it is below 2 keeps the FIFO from overflowing and
    // still sustains one word per cycle with dump_ready held high.
    assign occ_after   = fifo_cnt_q + {1'b0, dump_pend_q} - {1'b0, dump_pop};
    assign dump_rd     = (state_q == S_DUMP) & (dump_ptr_q < DEPTH_P) & (occ_after < 2'd2);

    // dataR is the RAM output right after an accelerator read, zero after an
    // out-of-range read, and otherwise holds, so dump traffic and writes never
    // disturb what the accelerator sees.
    assign dataR       = acc_rd_q ? rd_q : (acc_zero_q ? 32'd0 : data_r_hold_q);

    assign start       = start_q;
    assign load_ready  = load_ready_q;
    assign frame_done  = frame_done_q;
    assign frames      = frames_q;

    // Next state and single-port RAM control; the owners are state-exclusive.
    always_comb begin
        state_d   = state_q;
        ram_we    = acc_wr;
        ram_re    = acc_rd;
        ram_addr  = addr[AW-1:0];
        ram_wdata = dataW;
        case (state_q)
            S_LOAD: begin
                if (load_fire) begin
                    ram_we    = 1'b1;
                    ram_addr  = load_ptr_q;
                    ram_wdata = load_data;
                end
                if (load_last) state_d = S_START;
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (finish) state_d = S_DUMP;
            end
            S_DUMP: begin
                if (dump_rd) begin
                    ram_re   = 1'b1;
                    ram_addr = dump_ptr_q[AW-1:0];
                end
                if (dump_last) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Block RAM: contents survive reset, read data registered.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) rd_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_LOAD;
            load_ptr_q    <= '0;
            out_cnt_q     <= '0;
            dump_ptr_q    <= IMG_P;
            dump_pend_q   <= 1'b0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_cnt_q    <= '0;
            acc_rd_q      <= 1'b0;
            acc_zero_q    <= 1'b0;
            data_r_hold_q <= '0;
            start_q       <= 1'b0;
            load_ready_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frames_q      <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= (state_q == S_START);
            load_ready_q  <= (state_d == S_LOAD);
            frame_done_q  <= dump_last;
            acc_rd_q      <= acc_rd;
            acc_zero_q    <= acc_rd_zero;
            data_r_hold_q <= dataR;
            dump_pend_q   <= dump_rd;
            fifo_cnt_q    <= fifo_cnt_q + {1'b0, dump_pend_q} - {1'b0, dump_pop};

            if (load_fire) load_ptr_q <= load_last ? '0 : load_ptr_q + AW'(1);
            if (dump_rd)   dump_ptr_q <= dump_ptr_q + (AW+1)'(1);
            if (dump_pend_q) begin
                fifo_q[fifo_wr_q] <= rd_q;
                fifo_wr_q         <= ~fifo_wr_q;
            end
            if (dump_pop) begin
                fifo_rd_q <= ~fifo_rd_q;
                out_cnt_q <= dump_last ? '0 : out_cnt_q + AW'(1);
            end
            if (dump_last) begin
                frames_q   <= frames_q + 8'd1;
                dump_ptr_q <= IMG_P;
            end
        end
    end

`ifdef ACC_MEM_BOUNDS_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else if ((state_q == S_RUN) & en & acc_oor) err_q <= 1'b1;
    end
    assign err = err_q;
`endif

endmodule

// File: tb/tb_acc_mem_host.sv
`timescale 1ns/1ps
module tb_acc_mem_host;

    localparam int IMG = 256;
    localparam int DEP = 2 * IMG;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [31:0] dataW;
    logic        en, we;
    logic [31:0] dataR;
    logic        start;
    logic        finish;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        dump_valid;
    logic [31:0] dump_data;
    logic        dump_ready;
    logic        frame_done;
    logic [7:0]  frames;
`ifdef ACC_MEM_BOUNDS_CHECK_EN
    logic        err;
`endif

    acc_mem_host #(.IMG_WORDS(IMG), .DEPTH(DEP)) dut (
        .clk(clk), .reset(reset), .addr(addr), .dataW(dataW), .en(en), .we(we),
        .dataR(dataR), .start(start), .finish(finish),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
        .frame_done(frame_done),
`ifdef ACC_MEM_BOUNDS_CHECK_EN
        .err(err),
`endif
        .frames(frames)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int fd_cnt = 0;

    // Pulse-width counters: each cycle the signal is high adds one.
    always @(posedge clk) begin
        if (start === 1'b1) start_cnt <= start_cnt + 1;
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] in_word(input int tag, input int i);
        return 32'h1000_0000 | 32'(tag << 20) | 32'(i);
    endfunction

    function automatic logic [31:0] out_word(input int tag, input int i);
        return 32'hA000_0000 | 32'(tag << 20) | 32'(i * 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_dataR", dataR, 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_dump_data", dump_data, 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frames", 32'(frames), 32'd0);
`ifdef ACC_MEM_BOUNDS_CHECK_EN
        check("rst_err", 32'(err), 32'd0);
`endif
    endtask

    task automatic acc_write(input int a, input logic [31:0] d);
        addr = 16'(a); dataW = d; en = 1'b1; we = 1'b1;
        tick();
        en = 1'b0; we = 1'b0;
        $display("acc wr addr=%0d data=0x%08h", a, d);
    endtask

    task automatic acc_read(input string tag, input int a, input logic [31:0] exp);
        addr = 16'(a); en = 1'b1; we = 1'b0;
        tick();
        en = 1'b0;
        $display("acc rd addr=%0d dataR=0x%08h expect=0x%08h", a, dataR, exp);
        check(tag, dataR, exp);
    endtask

    // Streams one input frame, then checks the start pulse timing.
    task automatic load_frame(input int tag);
        int ok = 1;
        int s0 = start_cnt;
        for (int i = 0; i < IMG; i++) begin
            load_valid = 1'b1;
            load_data  = in_word(tag, i);
            if (load_ready !== 1'b1) ok = 0;
            tick();
        end
        load_valid = 1'b0;
        check("load_ready_held", 32'(ok), 32'd1);
        check("load_ready_drop", 32'(load_ready), 32'd0);
        check("start_not_yet", 32'(start), 32'd0);
        tick();
        check("start_pulse", 32'(start), 32'd1);
        tick();
        check("start_end", 32'(start), 32'd0);
        check("start_once", 32'(start_cnt - s0), 32'd1);
        $display("frame %0d loaded: %0d words", tag, IMG);
    endtask

    task automatic write_outputs(input int tag);
        for (int i = 0; i < IMG; i++) begin
            addr = 16'(IMG + i); dataW = out_word(tag, i); en = 1'b1; we = 1'b1;
            tick();
        end
        en = 1'b0; we = 1'b0;
        $display("frame %0d output region written", tag);
    endtask

    int r_idx, r_bad, r_stall_bad, r_bubbles, r_lat;

    // Raises finish for one cycle, then drains up to stop_at words with
    // dump_ready either held high (full) or cycling 1,0,0,1.
    task automatic dump_frame(input int tag, input bit full, input int stop_at);
        int cyc = 0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic [31:0] exp_w;
        r_idx = 0; r_bad = 0; r_stall_bad = 0; r_bubbles = 0; r_lat = -1;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        while (r_idx < stop_at && cyc < 6 * IMG + 20) begin
            if (prev_stall && (dump_valid !== 1'b1 || dump_data !== prev_data)) r_stall_bad++;
            if (r_lat < 0 && dump_valid === 1'b1) r_lat = cyc;
            if (full && r_lat >= 0 && dump_valid !== 1'b1) r_bubbles++;
            dump_ready = full ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (dump_valid === 1'b1 && dump_ready) begin
                exp_w = out_word(tag, r_idx);
                if (dump_data !== exp_w) begin
                    if (r_bad == 0) check("dump_data", dump_data, exp_w);
                    r_bad++;
                end
                r_idx++;
            end
            prev_stall = (dump_valid === 1'b1) && !dump_ready;
            prev_data  = dump_data;
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        $display("frame %0d dump: %0d words, %0d bad, latency %0d", tag, r_idx, r_bad, r_lat);
    endtask

    task automatic finish_frame_checks(input int exp_frames, input int fd0);
        check("dump_count", 32'(r_idx), 32'(IMG));
        check("dump_bad_words", 32'(r_bad), 32'd0);
        check("dump_stall_stable", 32'(r_stall_bad), 32'd0);
        tick();
        tick();
        check("frame_done_once", 32'(fd_cnt - fd0), 32'd1);
        check("frames", 32'(frames), 32'(exp_frames));
        check("dump_valid_idle", 32'(dump_valid), 32'd0);
        check("back_to_load", 32'(load_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        logic [31:0] prev;
        reset = 1'b1; addr = '0; dataW = '0; en = 1'b0; we = 1'b0; finish = 1'b0;
        load_valid = 1'b0; load_data = '0; dump_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();
        check("load_ready_after_rst", 32'(load_ready), 32'd1);

        // Frame 1: load, bus access, bounds, dump with backpressure.
        load_frame(1);
        acc_read("rd_first_word", 0, in_word(1, 0));
        acc_read("rd_last_word", IMG - 1, in_word(1, IMG - 1));
        acc_read("rd_addr5", 5, in_word(1, 5));
        prev = dataR;
        acc_write(IMG, 32'hDEADBEEF);
        check("write_keeps_dataR", dataR, prev);
        acc_read("rd_after_wr", IMG, 32'hDEADBEEF);
`ifdef ACC_MEM_BOUNDS_CHECK_EN
        check("err_before_oor", 32'(err), 32'd0);
`endif
        acc_write(DEP, 32'h1234_5678);
`ifdef ACC_MEM_BOUNDS_CHECK_EN
        check("err_set", 32'(err), 32'd1);
`endif
        acc_write(60000, 32'hCAFE_F00D);
        acc_read("oor_no_alias0", 0, in_word(1, 0));
        acc_read("oor_no_alias96", 96, in_word(1, 96));
        acc_read("oor_rd_60000", 60000, 32'd0);
        acc_read("oor_rd_depth", DEP, 32'd0);
`ifdef ACC_MEM_BOUNDS_CHECK_EN
        check("err_sticky", 32'(err), 32'd1);
`endif
        write_outputs(1);
        acc_read("rd_top_word", DEP - 1, out_word(1, IMG - 1));
        fd0 = fd_cnt;
        dump_frame(1, 1'b0, IMG);
        finish_frame_checks(1, fd0);

        // Frame 2: full-rate dump; bus is ignored outside RUN.
        check("dataR_hold_load", dataR, out_word(1, IMG - 1));
        acc_read("rd_ignored_load", 0, out_word(1, IMG - 1));
        load_frame(2);
        write_outputs(2);
        fd0 = fd_cnt;
        dump_frame(2, 1'b1, IMG);
        check("dump_latency_le3", 32'(r_lat >= 0 && r_lat <= 3), 32'd1);
        check("full_rate_bubbles", 32'(r_bubbles), 32'd0);
        finish_frame_checks(2, fd0);

        // Frame 3: bus write in LOAD is ignored; reset after 100 dump words.
        acc_write(DEP - 1, 32'h0BAD_0BAD);
        load_frame(3);
        acc_read("wr_ignored_load", DEP - 1, out_word(2, IMG - 1));
        write_outputs(3);
        dump_frame(3, 1'b1, 100);
        check("mid_dump_count", 32'(r_idx), 32'd100);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        tick();
        reset = 1'b0;
        tick();
        check("load_ready_after_mid_rst", 32'(load_ready), 32'd1);

        // Frame 4: a clean frame after the mid-dump reset.
        load_frame(4);
        write_outputs(4);
        fd0 = fd_cnt;
        dump_frame(4, 1'b1, IMG);
        finish_frame_checks(1, fd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
